// File: rtl/fp_div_seq.sv
// fp_div_seq: front-end controller for a multi-cycle floating-point divider.
// Accepts one operand pair at a time and resolves IEEE special cases locally.
// All other pairs are handed to the core through a start/done handshake, and a
// watchdog abandons the core if it does not answer in time. The result is held
// on a valid/ready output until the consumer takes it.
module fp_div_seq #(
  parameter int DATA_W  = 32,
  parameter int EXP_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] res_o,
  output logic              bypass_o,
  output logic              timeout_o,
  output logic              core_start_o,
  output logic              core_abort_o,
  output logic [DATA_W-1:0] core_a_o,
  output logic [DATA_W-1:0] core_b_o,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_res_i
);

  localparam int FRAC_W = DATA_W - EXP_W - 1;
  localparam int CNT_W  = $clog2(TIMEOUT);

  // Canonical quiet NaN: positive, exponent all ones, only the fraction MSB set.
  localparam logic [DATA_W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   wd_cnt;

  // Operand fields, taken straight from the inputs on the accept cycle.
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, res_sign;
  logic              is_special;
  logic [DATA_W-1:0] special_res;
  logic              wd_expire;

  assign exp_a  = op_a_i[DATA_W-2 -: EXP_W];
  assign exp_b  = op_b_i[DATA_W-2 -: EXP_W];
  assign frac_a = op_a_i[FRAC_W-1:0];
  assign frac_b = op_b_i[FRAC_W-1:0];

  assign a_nan  = (&exp_a) & (|frac_a);
  assign a_inf  = (&exp_a) & ~(|frac_a);
  assign a_zero = ~(|exp_a) & ~(|frac_a);
  assign b_nan  = (&exp_b) & (|frac_b);
  assign b_inf  = (&exp_b) & ~(|frac_b);
  assign b_zero = ~(|exp_b) & ~(|frac_b);

  assign res_sign  = op_a_i[DATA_W-1] ^ op_b_i[DATA_W-1];
  assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));

  // Handshake outputs decode the state register only, so no input reaches them.
  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == RESP);

  // Special-case resolver, written as a priority chain (first match wins).
  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    is_special  = 1'b1;
    special_res = QNAN;
    if (a_nan || b_nan) begin
      special_res = QNAN;
    end else if (a_inf && b_inf) begin
      special_res = QNAN;
    end else if (a_zero && b_zero) begin
      special_res = QNAN;
    end else if (a_inf || b_zero) begin
      special_res = {res_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
    end else if (a_zero || b_inf) begin
      special_res = {res_sign, {(DATA_W-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state <= IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (in_valid_i) state_nxt = is_special ? RESP : START;
      START: state_nxt = WAIT;
      WAIT:  if (core_done_i || wd_expire) state_nxt = RESP;
      RESP:  if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered datapath: operand latch, core pulses, watchdog, result capture.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      res_o        <= '0;
      bypass_o     <= 1'b0;
      timeout_o    <= 1'b0;
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
      core_a_o     <= '0;
      core_b_o     <= '0;
      wd_cnt       <= '0;
    end else begin
      // Start and abort are single-cycle pulses unless re-armed below.
      core_start_o <= 1'b0;
      core_abort_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            core_a_o <= op_a_i;
            core_b_o <= op_b_i;
            if (is_special) begin
              res_o     <= special_res;
              bypass_o  <= 1'b1;
              timeout_o <= 1'b0;
            end else begin
              // High during the START state, one cycle after accept.
              core_start_o <= 1'b1;
            end
          end
        end
        START: wd_cnt <= '0;
        WAIT: begin
          // A done arriving on the expiry cycle still wins over the watchdog.
          if (core_done_i) begin
            res_o     <= core_res_i;
            bypass_o  <= 1'b0;
            timeout_o <= 1'b0;
          end else if (wd_expire) begin
            res_o        <= QNAN;
            bypass_o     <= 1'b0;
            timeout_o    <= 1'b1;
            core_abort_o <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
          end
        end
        default: ; // RESP holds the result until it is taken
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Self-checking bench for fp_div_seq: directed cases plus randomized operand
// pairs, each checked against a classification-based reference model.
module tb_fp_div_seq;

  localparam int DATA_W  = 32;
  localparam int EXP_W   = 8;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] res_o;
  logic        bypass_o;
  logic        timeout_o;
  logic        core_start_o;
  logic        core_abort_o;
  logic [31:0] core_a_o;
  logic [31:0] core_b_o;
  logic        core_done_i = 1'b0;
  logic [31:0] core_res_i = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  fp_div_seq #(.DATA_W(DATA_W), .EXP_W(EXP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_a_i(op_a_i), .op_b_i(op_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .res_o(res_o), .bypass_o(bypass_o), .timeout_o(timeout_o),
    .core_start_o(core_start_o), .core_abort_o(core_abort_o),
    .core_a_o(core_a_o), .core_b_o(core_b_o),
    .core_done_i(core_done_i), .core_res_i(core_res_i)
  );

  // ---------------- reference model ----------------
  typedef enum {C_NAN, C_INF, C_ZERO, C_FIN} cls_t;

  function automatic cls_t classify(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? C_NAN : C_INF;
    if (x[30:0] == 0) return C_ZERO;
    return C_FIN;
  endfunction

  // Returns 1 when the pair never reaches the core; r is then the IEEE answer.
  function automatic bit model_special(input logic [31:0] a, input logic [31:0] b,
                                       output logic [31:0] r);
    cls_t ca = classify(a);
    cls_t cb = classify(b);
    logic s  = a[31] ^ b[31];
    r = '0;
    if (ca == C_NAN || cb == C_NAN || (ca == C_INF && cb == C_INF) ||
        (ca == C_ZERO && cb == C_ZERO)) begin
      r = QNAN; return 1'b1;
    end
    if (ca == C_INF || cb == C_ZERO) begin
      r = {s, 8'hFF, 23'h0}; return 1'b1;
    end
    if (ca == C_ZERO || cb == C_INF) begin
      r = {s, 31'h0}; return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_op();
    logic s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      1: return {s, 8'hFF, 23'h0};
      2: return {s, 31'h0};
      3: return {s, 8'h00, 23'($urandom_range(1, 23'h7FFFFF))};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // ---------------- scenario driver ----------------
  // Issues one pair; the core answers core_val d cycles after START
  // (d outside 1..TIMEOUT means never). Holds the result for `hold` cycles
  // of backpressure while offering fresh operands, then drains it.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int d,
                        input logic [31:0] core_val, input int hold, input string tag);
    logic [31:0] exp_res;
    bit          sp, exp_to, core_answers;
    int          exp_cyc, cyc, starts, aborts;
    sp           = model_special(a, b, exp_res);
    core_answers = !sp && d >= 1 && d <= TIMEOUT;
    exp_to       = !sp && !core_answers;
    if (sp)                exp_cyc = 1;
    else if (core_answers) begin exp_cyc = 2 + d; exp_res = core_val; end
    else                   begin exp_cyc = TIMEOUT + 2; exp_res = QNAN; end
    starts = 0; aborts = 0; cyc = 0;

    @(negedge clk_i);
    vectors++;
    if (in_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL %s in_ready before accept: got %b want 1", tag, in_ready_o);
    end
    in_valid_i  = 1'b1;
    op_a_i      = a;
    op_b_i      = b;
    out_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      cyc++;
      in_valid_i  = 1'b0;
      core_done_i = 1'b0;
      core_res_i  = $urandom;
      if (core_start_o === 1'b1) starts++;
      if (core_abort_o === 1'b1) aborts++;
      if (out_valid_o === 1'b1 || cyc >= 40) break;
      if (!sp && d >= 1 && cyc == 1 + d) begin
        core_done_i = 1'b1;
        core_res_i  = core_val;
      end
    end

    vectors++;
    if (cyc != exp_cyc || out_valid_o !== 1'b1) begin
      miscompares++; $display("FAIL %s latency: got %0d cycles want %0d", tag, cyc, exp_cyc);
      return;
    end
    vectors++;
    if (res_o !== exp_res) begin
      miscompares++; $display("FAIL %s res: got %h want %h", tag, res_o, exp_res);
    end
    vectors++;
    if (bypass_o !== sp || timeout_o !== exp_to) begin
      miscompares++;
      $display("FAIL %s flags: got bypass=%b timeout=%b want bypass=%b timeout=%b",
               tag, bypass_o, timeout_o, sp, exp_to);
    end
    vectors++;
    if (starts != (sp ? 0 : 1) || aborts != int'(exp_to)) begin
      miscompares++;
      $display("FAIL %s core pulses: got start=%0d abort=%0d want start=%0d abort=%0d",
               tag, starts, aborts, sp ? 0 : 1, int'(exp_to));
    end
    vectors++;
    if (core_a_o !== a || core_b_o !== b) begin
      miscompares++;
      $display("FAIL %s core operands: got %h/%h want %h/%h", tag, core_a_o, core_b_o, a, b);
    end

    for (int h = 0; h < hold; h++) begin
      in_valid_i  = 1'b1;
      op_a_i      = $urandom;
      op_b_i      = $urandom;
      core_done_i = 1'($urandom_range(0, 1));
      core_res_i  = $urandom;
      @(negedge clk_i);
      vectors++;
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || res_o !== exp_res ||
          bypass_o !== sp || timeout_o !== exp_to || core_a_o !== a || core_b_o !== b ||
          core_start_o !== 1'b0 || core_abort_o !== 1'b0) begin
        miscompares++;
        $display("FAIL %s hold[%0d]: got v=%b rdy=%b res=%h a=%h b=%h st=%b ab=%b want v=1 rdy=0 res=%h a=%h b=%h st=0 ab=0",
                 tag, h, out_valid_o, in_ready_o, res_o, core_a_o, core_b_o,
                 core_start_o, core_abort_o, exp_res, a, b);
      end
    end

    in_valid_i  = 1'b0;
    core_done_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    out_ready_i = 1'b0;
    vectors++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s drain: got valid=%b ready=%b want valid=0 ready=1", tag, out_valid_o, in_ready_o);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #3 arst_n_i = 1'b0;
    #2;
    vectors++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || res_o !== 32'h0 || bypass_o !== 1'b0 ||
        timeout_o !== 1'b0 || core_start_o !== 1'b0 || core_abort_o !== 1'b0 ||
        core_a_o !== 32'h0 || core_b_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset state: got rdy=%b v=%b res=%h byp=%b to=%b st=%b ab=%b a=%h b=%h want rdy=1 and all else 0",
               in_ready_o, out_valid_o, res_o, bypass_o, timeout_o, core_start_o,
               core_abort_o, core_a_o, core_b_o);
    end
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    @(negedge clk_i);
    vectors++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset release: got rdy=%b v=%b want rdy=1 v=0", in_ready_o, out_valid_o);
    end
  endtask

  task automatic test_divide();
    run_op(32'h40C0_0000, 32'h4000_0000, 5, 32'h4040_0000, 0, "div_6_2");
  endtask

  task automatic test_bypass();
    run_op(32'h3F80_0000, 32'h8000_0000, 3, 32'h1234_5678, 0, "one_by_negzero");
    run_op(32'h0000_0000, 32'h3F80_0000, 3, 32'h1234_5678, 0, "zero_by_one");
    run_op(32'h3F80_0000, 32'h7F80_0000, 3, 32'h1234_5678, 0, "one_by_inf");
  endtask

  task automatic test_qnan();
    run_op(32'h7F80_0001, 32'h3F80_0000, 3, 32'h1234_5678, 0, "nan_by_one");
    run_op(32'h7F80_0000, 32'hFF80_0000, 3, 32'h1234_5678, 0, "inf_by_neginf");
    run_op(32'h0000_0000, 32'h8000_0000, 3, 32'h1234_5678, 0, "zero_by_negzero");
  endtask

  task automatic test_timeout();
    run_op(32'h3F80_0000, 32'h4000_0000, 0, 32'h3F00_0000, 0, "timeout");
    run_op(32'h3F80_0000, 32'h4000_0000, TIMEOUT, 32'h3F00_0000, 0, "done_on_expiry");
    run_op(32'h3F80_0000, 32'h4000_0000, TIMEOUT - 1, 32'h3F00_0000, 0, "done_before_expiry");
  endtask

  task automatic test_backpressure();
    run_op(32'h40C0_0000, 32'h4000_0000, 4, 32'h4040_0000, 10, "bp_core");
    run_op(32'hBF80_0000, 32'h0000_0000, 1, 32'h0, 10, "bp_bypass");
  endtask

  task automatic test_reset_wait();
    @(negedge clk_i);
    in_valid_i = 1'b1;
    op_a_i     = 32'h40C0_0000;
    op_b_i     = 32'h4000_0000;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    arst_n_i = 1'b0;
    #1;
    vectors++;
    if (out_valid_o !== 1'b0 || core_start_o !== 1'b0 || core_abort_o !== 1'b0 || in_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wait: got v=%b st=%b ab=%b rdy=%b want v=0 st=0 ab=0 rdy=1",
               out_valid_o, core_start_o, core_abort_o, in_ready_o);
    end
    repeat (2) @(negedge clk_i);
    arst_n_i    = 1'b1;
    core_done_i = 1'b1;
    core_res_i  = 32'hDEAD_BEEF;
    @(negedge clk_i);
    core_done_i = 1'b0;
    repeat (2) begin
      @(negedge clk_i);
      vectors++;
      if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || res_o !== 32'h0) begin
        miscompares++;
        $display("FAIL stale_done: got v=%b rdy=%b res=%h want v=0 rdy=1 res=00000000",
                 out_valid_o, in_ready_o, res_o);
      end
    end
    run_op(32'h3F80_0000, 32'h3F80_0000, 3, 32'h3F80_0000, 1, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_op(rand_op(), rand_op(), $urandom_range(1, TIMEOUT + 4), $urandom,
             $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_bypass();
    test_qnan();
    test_timeout();
    test_backpressure();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
